// File: rtl/gpu_pkg.sv
// Shared definitions for the tile compositor: register map, tile word layout,
// screen/tile geometry and the renderer FSM state encoding.
package gpu_pkg;

  // Register indices; scroll registers are interleaved x/y per layer from the base.
  localparam int REG_ENABLE      = 0;
  localparam int REG_BG          = 1;
  localparam int REG_SCROLL_BASE = 2;

  // Tile word: foreground colour in the high byte, glyph code in the low byte.
  localparam int TILE_COLOUR_MSB = 15;
  localparam int TILE_COLOUR_LSB = 8;
  localparam int TILE_CODE_MSB   = 7;
  localparam int TILE_CODE_LSB   = 0;

  localparam int TILE_SIZE = 8;
  localparam int SCREEN_W  = 96;
  localparam int SCREEN_H  = 64;

  // Scroll register widths follow the screen coordinate widths.
  localparam int SCROLL_XW = $clog2(SCREEN_W);
  localparam int SCROLL_YW = $clog2(SCREEN_H);

  typedef enum logic [2:0] {
    IDLE,
    MAP,
    GLYPH,
    PIX,
    DONE
  } state_t;

  function automatic logic [7:0] tile_colour(input logic [15:0] word);
    return word[TILE_COLOUR_MSB:TILE_COLOUR_LSB];
  endfunction

  function automatic logic [7:0] tile_code(input logic [15:0] word);
    return word[TILE_CODE_MSB:TILE_CODE_LSB];
  endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Dual-port map RAM.
//   Port A: CPU read/write with per-byte enables, read-first, 1-cycle read latency.
//   Port B: renderer read-only, 1-cycle read latency.
// A port-B read of the address port A is writing returns the old word.
module dual_port_ram #(
  parameter int AW      = 8,
  parameter int DEPTH_A = 2**AW
) (
  input  logic          clk,
  input  logic [1:0]    i_we_a,
  input  logic [AW-1:0] i_addr_a,
  input  logic [15:0]   i_din_a,
  output logic [15:0]   o_dout_a,
  input  logic [AW-1:0] i_addr_b,
  output logic [15:0]   o_dout_b
);

  logic [15:0] r_mem [DEPTH_A];

  always_ff @(posedge clk) begin
    o_dout_a <= r_mem[i_addr_a];
    o_dout_b <= r_mem[i_addr_b];
    if (i_we_a[0]) r_mem[i_addr_a][7:0]  <= i_din_a[7:0];
    if (i_we_a[1]) r_mem[i_addr_a][15:8] <= i_din_a[15:8];
  end

endmodule

// File: rtl/layer_regs.sv
// Write-only configuration registers for the compositor: layer enable mask,
// background colour and per-layer scroll offsets, plus a combinational mux
// that presents the scroll/enable values of one selected layer.
//   clk, rst          : clock, synchronous active-high reset
//   i_we/i_addr/i_data: CPU register write
//   i_sel             : layer currently being rendered
//   o_bg              : background colour
//   o_scroll_x/_y     : scroll of the selected layer
//   o_sel_en          : enable bit of the selected layer
module layer_regs
  import gpu_pkg::*;
#(
  parameter int LAYERS = 2,
  parameter int LW     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [3:0]           i_addr,
  input  logic [15:0]          i_data,
  input  logic [LW-1:0]        i_sel,
  output logic [7:0]           o_bg,
  output logic [SCROLL_XW-1:0] o_scroll_x,
  output logic [SCROLL_YW-1:0] o_scroll_y,
  output logic                 o_sel_en
);

  logic [LAYERS-1:0]    r_enable;
  logic [7:0]           r_bg;
  logic [SCROLL_XW-1:0] r_sx [LAYERS];
  logic [SCROLL_YW-1:0] r_sy [LAYERS];
  logic                 w_unused_data;

  // The top byte of the write data never lands in any register.
  assign w_unused_data = ^i_data[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable <= '0;
      r_bg     <= '0;
      for (int l = 0; l < LAYERS; l++) begin
        r_sx[l] <= '0;
        r_sy[l] <= '0;
      end
    end else if (i_we) begin
      if (i_addr == 4'(REG_ENABLE)) r_enable <= i_data[LAYERS-1:0];
      if (i_addr == 4'(REG_BG))     r_bg     <= i_data[7:0];
      for (int l = 0; l < LAYERS; l++) begin
        if (i_addr == 4'(REG_SCROLL_BASE + 2*l))     r_sx[l] <= i_data[SCROLL_XW-1:0];
        if (i_addr == 4'(REG_SCROLL_BASE + 2*l + 1)) r_sy[l] <= i_data[SCROLL_YW-1:0];
      end
    end
  end

  assign o_bg = r_bg;

  always_comb begin
    o_scroll_x = '0;
    o_scroll_y = '0;
    o_sel_en   = 1'b0;
    for (int l = 0; l < LAYERS; l++) begin
      if (i_sel == LW'(l)) begin
        o_scroll_x = r_sx[l];
        o_scroll_y = r_sy[l];
        o_sel_en   = r_enable[l];
      end
    end
  end

endmodule

// File: rtl/tile_compositor.sv
// Multi-layer tilemap compositor. Holds LAYERS scrollable tilemaps in a shared
// map RAM, fetches glyph rows from an external glyph ROM and returns one
// priority-composited RGB332 pixel per accepted request.
//   clk, rst                      : clock, synchronous active-high reset
//   map_we/map_addr/map_data/map_q: CPU map port (byte enables, 1-cycle read)
//   reg_we/reg_addr/reg_data      : CPU register writes
//   pixel_re/pixel_ready          : request handshake, pixel_x/pixel_y latched on accept
//   pixel_valid/pixel_data        : one-cycle result pulse, data held until next result
//   glyph_addr/glyph_data         : glyph ROM port, 1-cycle latency
//
// state | meaning
// IDLE  | ready for a request
// MAP   | compute virtual coords of layer l, address the map RAM
// GLYPH | tile word available; latch colour, address the glyph ROM
// PIX   | glyph row available; resolve layer l, advance layer or finish
// DONE  | publish the composited pixel
module tile_compositor
  import gpu_pkg::*;
#(
  parameter int LAYERS   = 2,
  parameter int MAP_COLS = 16,
  parameter int MAP_ROWS = 8,
  parameter int MAP_AW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        map_we,
  input  logic [MAP_AW-1:0] map_addr,
  input  logic [15:0]       map_data,
  output logic [15:0]       map_q,
  input  logic              reg_we,
  input  logic [3:0]        reg_addr,
  input  logic [15:0]       reg_data,
  input  logic              pixel_re,
  output logic              pixel_ready,
  input  logic [6:0]        pixel_x,
  input  logic [5:0]        pixel_y,
  output logic              pixel_valid,
  output logic [7:0]        pixel_data,
  output logic [10:0]       glyph_addr,
  input  logic [7:0]        glyph_data
);

  localparam int LW   = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int TB   = $clog2(TILE_SIZE);
  localparam int CB   = $clog2(MAP_COLS);
  localparam int RB   = $clog2(MAP_ROWS);
  localparam int VXW  = CB + TB;
  localparam int VYW  = RB + TB;
  localparam logic [LW-1:0] LAST_LAYER = LW'(LAYERS - 1);

  state_t               r_state;
  logic [LW-1:0]        r_layer;
  logic                 r_hit;
  logic [7:0]           r_result;
  logic [7:0]           r_colour;
  logic [6:0]           r_x;
  logic [5:0]           r_y;
  logic [TB-1:0]        r_vx_lo;
  logic [TB-1:0]        r_vy_lo;
  logic                 r_ready;
  logic                 r_valid;
  logic [7:0]           r_data;

  logic [SCROLL_XW-1:0] w_sx;
  logic [SCROLL_YW-1:0] w_sy;
  logic                 w_sel_en;
  logic [7:0]           w_bg;
  logic [VXW-1:0]       w_vx;
  logic [VYW-1:0]       w_vy;
  logic [MAP_AW-1:0]    w_addr_b;
  logic [15:0]          w_q_b;
  logic                 w_bit;

  layer_regs #(
    .LAYERS (LAYERS),
    .LW     (LW)
  ) u_regs (
    .clk        (clk),
    .rst        (rst),
    .i_we       (reg_we),
    .i_addr     (reg_addr),
    .i_data     (reg_data),
    .i_sel      (r_layer),
    .o_bg       (w_bg),
    .o_scroll_x (w_sx),
    .o_scroll_y (w_sy),
    .o_sel_en   (w_sel_en)
  );

  dual_port_ram #(
    .AW      (MAP_AW),
    .DEPTH_A (2**MAP_AW)
  ) u_map (
    .clk      (clk),
    .i_we_a   (map_we),
    .i_addr_a (map_addr),
    .i_din_a  (map_data),
    .o_dout_a (map_q),
    .i_addr_b (w_addr_b),
    .o_dout_b (w_q_b)
  );

  // Truncation to the virtual map width gives the wrap-around for free.
  assign w_vx = VXW'(r_x) + VXW'(w_sx);
  assign w_vy = VYW'(r_y) + VYW'(w_sy);

  assign w_addr_b = MAP_AW'({r_layer, w_vy[VYW-1:TB], w_vx[VXW-1:TB]});

  // The glyph address depends on the tile word arriving this cycle, so it is
  // driven combinationally while in GLYPH and parked at zero otherwise.
  assign glyph_addr = (r_state == GLYPH) ? {tile_code(w_q_b), r_vy_lo} : '0;

  // Bit 7 of the glyph row is the leftmost pixel of the tile.
  assign w_bit = glyph_data[3'd7 - r_vx_lo];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_layer  <= '0;
      r_hit    <= 1'b0;
      r_result <= '0;
      r_colour <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_vx_lo  <= '0;
      r_vy_lo  <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (pixel_re && r_ready) begin
            r_x     <= pixel_x;
            r_y     <= pixel_y;
            r_layer <= '0;
            r_hit   <= 1'b0;
            r_ready <= 1'b0;
            r_state <= MAP;
          end
        end
        MAP: begin
          r_vx_lo <= w_vx[TB-1:0];
          r_vy_lo <= w_vy[TB-1:0];
          r_state <= GLYPH;
        end
        GLYPH: begin
          r_colour <= tile_colour(w_q_b);
          r_state  <= PIX;
        end
        PIX: begin
          // Layers are visited in priority order, so the first hit wins.
          if (w_bit && w_sel_en && !r_hit) begin
            r_result <= r_colour;
            r_hit    <= 1'b1;
          end
          if (r_layer == LAST_LAYER) begin
            r_state <= DONE;
          end else begin
            r_layer <= r_layer + LW'(1);
            r_state <= MAP;
          end
        end
        DONE: begin
          r_data  <= r_hit ? r_result : w_bg;
          r_valid <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign pixel_ready = r_ready;
  assign pixel_valid = r_valid;
  assign pixel_data  = r_data;

endmodule

// File: tb/tb_tile_compositor.sv
module tb_tile_compositor;

  localparam int LAYERS   = 2;
  localparam int MAP_COLS = 16;
  localparam int MAP_ROWS = 8;
  localparam int MAP_AW   = 8;
  localparam int MAP_WORDS = 2**MAP_AW;
  localparam int LAT      = 3*LAYERS + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        map_we = '0;
  logic [MAP_AW-1:0] map_addr = '0;
  logic [15:0]       map_data = '0;
  logic [15:0]       map_q;
  logic              reg_we = 1'b0;
  logic [3:0]        reg_addr = '0;
  logic [15:0]       reg_data = '0;
  logic              pixel_re = 1'b0;
  logic              pixel_ready;
  logic [6:0]        pixel_x = '0;
  logic [5:0]        pixel_y = '0;
  logic              pixel_valid;
  logic [7:0]        pixel_data;
  logic [10:0]       glyph_addr;
  logic [7:0]        glyph_data = '0;

  always #5 clk = ~clk;

  tile_compositor #(
    .LAYERS   (LAYERS),
    .MAP_COLS (MAP_COLS),
    .MAP_ROWS (MAP_ROWS),
    .MAP_AW   (MAP_AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .map_we      (map_we),
    .map_addr    (map_addr),
    .map_data    (map_data),
    .map_q       (map_q),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .pixel_re    (pixel_re),
    .pixel_ready (pixel_ready),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data),
    .glyph_addr  (glyph_addr),
    .glyph_data  (glyph_data)
  );

  // External glyph ROM, 1-cycle latency.
  logic [7:0] rom [2048];
  always @(posedge clk) glyph_data <= rom[glyph_addr];

  // Reference state
  logic [15:0]       m_map [MAP_WORDS];
  logic [LAYERS-1:0] m_en;
  logic [7:0]        m_bg;
  int                m_sx [LAYERS];
  int                m_sy [LAYERS];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_pixel(input int x, input int y);
    for (int l = 0; l < LAYERS; l++) begin
      int vx;
      int vy;
      logic [15:0] w;
      logic [7:0] g;
      vx = (x + m_sx[l]) % (MAP_COLS*8);
      vy = (y + m_sy[l]) % (MAP_ROWS*8);
      w  = m_map[l*MAP_COLS*MAP_ROWS + (vy/8)*MAP_COLS + vx/8];
      g  = rom[int'(w[7:0])*8 + vy%8];
      if (m_en[l] && g[7 - vx%8]) return w[15:8];
    end
    return m_bg;
  endfunction

  task automatic map_write(input int a, input logic [1:0] we, input logic [15:0] d);
    @(negedge clk);
    map_we = we; map_addr = a[MAP_AW-1:0]; map_data = d;
    @(negedge clk);
    map_we = '0;
    if (we[0]) m_map[a][7:0]  = d[7:0];
    if (we[1]) m_map[a][15:8] = d[15:8];
  endtask

  task automatic map_read_check(input int a);
    @(negedge clk);
    map_we = '0; map_addr = a[MAP_AW-1:0];
    @(posedge clk); #1;
    check("map_q", 32'(map_q), 32'(m_map[a]));
  endtask

  task automatic reg_write(input int a, input logic [15:0] d);
    @(negedge clk);
    reg_we = 1'b1; reg_addr = a[3:0]; reg_data = d;
    @(negedge clk);
    reg_we = 1'b0;
    if (a == 0) m_en = d[LAYERS-1:0];
    else if (a == 1) m_bg = d[7:0];
    else for (int l = 0; l < LAYERS; l++) begin
      if (a == 2 + 2*l) m_sx[l] = int'(d[6:0]);
      if (a == 3 + 2*l) m_sy[l] = int'(d[5:0]);
    end
  endtask

  // Issue one request; optionally collide a CPU map write with the layer-0 fetch.
  task automatic request(input int x, input int y, input bit coll, input int caddr,
                         input logic [15:0] cdata, output logic [7:0] d, output int lat);
    int n;
    @(negedge clk);
    check("ready_idle", 32'(pixel_ready), 32'd1);
    pixel_re = 1'b1; pixel_x = x[6:0]; pixel_y = y[5:0];
    @(posedge clk); #1;
    pixel_re = 1'b0;
    if (coll) begin
      @(negedge clk);
      map_we = 2'b11; map_addr = caddr[MAP_AW-1:0]; map_data = cdata;
    end
    lat = -1;
    d = 'x;
    n = 0;
    while (n < 40 && lat < 0) begin
      @(posedge clk); #1;
      n++;
      if (coll && n == 1) map_we = '0;
      if (pixel_valid) begin
        lat = n;
        d = pixel_data;
      end
    end
    if (lat < 0) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic req_check(input string name, input int x, input int y, input logic [7:0] exp);
    logic [7:0] d;
    int lat;
    request(x, y, 1'b0, 0, '0, d, lat);
    check({name, "_lat"}, 32'(lat), 32'(LAT));
    check(name, 32'(d), 32'(exp));
  endtask

  typedef struct {
    int         phase;
    int         x;
    int         y;
    logic [7:0] exp;
  } vec_t;

  task automatic apply_phase(input int p);
    case (p)
      0: begin reg_write(1, 16'h00E0); reg_write(0, 16'h0000); end
      1: begin
        reg_write(0, 16'h0001);
        map_write(0, 2'b11, 16'h1C41);
        rom[16'h41*8] = 8'h80;
      end
      2: begin
        map_write(0, 2'b11, 16'h0341);
        map_write(128, 2'b11, 16'hFC42);
        rom[16'h42*8] = 8'hFF;
        reg_write(0, 16'h0003);
      end
      3: reg_write(0, 16'h0002);
      4: begin rom[16'h42*8] = 8'h40; reg_write(4, 16'd125); end
      5: reg_write(5, 16'd60);
      default: ;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[15];
    logic [7:0] d, e;
    int lat, seen, prev_phase;
    int vat[$];
    logic [7:0] vdat[$];
    logic [7:0] vexp[$];

    vecs[0]  = '{0, 5, 5, 8'hE0};
    vecs[1]  = '{1, 0, 0, 8'h1C};
    vecs[2]  = '{1, 1, 0, 8'hE0};
    vecs[3]  = '{1, 0, 1, 8'hE0};
    vecs[4]  = '{2, 0, 0, 8'h03};
    vecs[5]  = '{2, 1, 0, 8'hFC};
    vecs[6]  = '{2, 7, 0, 8'hFC};
    vecs[7]  = '{2, 8, 0, 8'hE0};
    vecs[8]  = '{3, 0, 0, 8'hFC};
    vecs[9]  = '{4, 4, 0, 8'hFC};
    vecs[10] = '{4, 5, 0, 8'hE0};
    vecs[11] = '{4, 3, 0, 8'hE0};
    vecs[12] = '{5, 4, 4, 8'hFC};
    vecs[13] = '{5, 4, 3, 8'hE0};
    vecs[14] = '{5, 0, 0, 8'hE0};

    for (int i = 0; i < 2048; i++) rom[i] = '0;
    m_en = '0; m_bg = '0;
    for (int l = 0; l < LAYERS; l++) begin m_sx[l] = 0; m_sy[l] = 0; end

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", 32'(pixel_ready), 32'd1);
    check("rst_valid", 32'(pixel_valid), 32'd0);
    check("rst_data", 32'(pixel_data), 32'd0);
    check("rst_glyph_addr", 32'(glyph_addr), 32'd0);

    for (int a = 0; a < MAP_WORDS; a++) map_write(a, 2'b11, 16'h0000);

    // Directed table
    prev_phase = -1;
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].phase != prev_phase) begin
        apply_phase(vecs[i].phase);
        prev_phase = vecs[i].phase;
      end
      req_check($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].exp);
      if (i == 1) begin
        repeat (3) @(posedge clk);
        #1;
        check("hold_data", 32'(pixel_data), 32'h1C);
        check("hold_valid", 32'(pixel_valid), 32'd0);
      end
    end

    // Reset in the middle of a request
    @(negedge clk);
    pixel_re = 1'b1; pixel_x = 7'd4; pixel_y = 6'd4;
    @(posedge clk); #1;
    pixel_re = 1'b0;
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      rst = (k == 2 || k == 3);
      @(posedge clk); #1;
      if (pixel_valid) seen++;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    check("midrst_ready", 32'(pixel_ready), 32'd1);
    check("midrst_data", 32'(pixel_data), 32'd0);
    m_en = '0; m_bg = '0;
    for (int l = 0; l < LAYERS; l++) begin m_sx[l] = 0; m_sy[l] = 0; end
    req_check("after_rst_regs", 0, 0, model_pixel(0, 0));
    reg_write(0, 16'h0001);
    req_check("after_rst_map", 0, 0, model_pixel(0, 0));

    // Collision: CPU writes the word the renderer is fetching in the same cycle
    e = model_pixel(0, 0);
    request(0, 0, 1'b1, 0, 16'h5541, d, lat);
    check("coll_lat", 32'(lat), 32'(LAT));
    check("coll_old_word", 32'(d), 32'(e));
    m_map[0] = 16'h5541;
    req_check("coll_new_word", 0, 0, model_pixel(0, 0));
    map_read_check(0);
    map_write(0, 2'b01, 16'hAA77);
    map_read_check(0);
    map_write(0, 2'b10, 16'h9900);
    map_read_check(0);

    // Randomised traffic against the reference model
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 80; i++)
      map_write($urandom_range(0, MAP_WORDS-1), 2'($urandom_range(1, 3)), 16'($urandom));
    for (int i = 0; i < 40; i++) begin
      int x, y;
      for (int j = 0; j < int'($urandom_range(0, 2)); j++)
        reg_write($urandom_range(0, 15), 16'($urandom));
      if (i % 4 == 0) reg_write(0, 16'($urandom));
      map_write($urandom_range(0, MAP_WORDS-1), 2'($urandom_range(1, 3)), 16'($urandom));
      if (i % 5 == 0) map_read_check($urandom_range(0, MAP_WORDS-1));
      x = $urandom_range(0, 95);
      y = $urandom_range(0, 63);
      req_check($sformatf("rand%0d", i), x, y, model_pixel(x, y));
    end

    // pixel_re held high: one accept every 3*LAYERS+2 cycles, the rest ignored
    reg_write(0, 16'h0003);
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      pixel_re = 1'b1;
      pixel_x = 7'((k*5) % 96);
      pixel_y = 6'((k*3) % 64);
      if (k % (LAT+1) == 0) vexp.push_back(model_pixel((k*5) % 96, (k*3) % 64));
      @(posedge clk); #1;
      if (pixel_valid) begin
        vat.push_back(k);
        vdat.push_back(pixel_data);
      end
    end
    pixel_re = 1'b0;
    check("busy_count", 32'(vat.size()), 32'd4);
    for (int i = 0; i < vat.size() && i < 4; i++) begin
      check($sformatf("busy_time%0d", i), 32'(vat[i]), 32'(i*(LAT+1) + LAT));
      check($sformatf("busy_data%0d", i), 32'(vdat[i]), 32'(vexp[i]));
    end
    repeat (12) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
